// File: rtl/energy_regulator_pkg.sv
// Shared types and constants for the multi-channel energy regulator.
// Holds the FSM encoding, net-counter limits and the drain-delta encoding.
package energy_regulator_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      DRN_NONE = 2'b00,
      DRN_POS  = 2'b01,
      DRN_NEG  = 2'b10
   } drain_t;

   localparam int CNT_W_DEF = 4;
   localparam int CNT_MAX   = (2 ** (CNT_W_DEF - 1)) - 1;
   localparam int CNT_MIN   = -(2 ** (CNT_W_DEF - 1));

   function automatic int cnt_max(input int w);
      return (2 ** (w - 1)) - 1;
   endfunction

   function automatic int cnt_min(input int w);
      return -(2 ** (w - 1));
   endfunction

   function automatic logic signed [1:0] in_delta(input logic inc, input logic dec);
      logic signed [1:0] d;
      case ({inc, dec})
         2'b10:   d = 2'sb01;
         2'b01:   d = 2'sb11;
         default: d = 2'sb00;
      endcase
      return d;
   endfunction

   function automatic logic signed [1:0] drain_val(input drain_t drn);
      logic signed [1:0] d;
      case (drn)
         DRN_POS: d = 2'sb01;
         DRN_NEG: d = 2'sb11;
         default: d = 2'sb00;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/energy_regulator_mc_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or above the pointer, wrapping around.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int PTR_W  = 2
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [PTR_W-1:0]  i_ptr,
   output logic [NUM_CH-1:0] o_grant,
   output logic              o_valid
);

   logic [NUM_CH-1:0]   w_rot_req;
   logic [NUM_CH-1:0]   w_rot_gnt;
   logic [2*NUM_CH-1:0] w_dbl_gnt;

   // Rotate requests so the pointer sits at bit 0, isolate lowest set bit, rotate back.
   always_comb begin
      w_rot_req = NUM_CH'({i_req, i_req} >> i_ptr);
      w_rot_gnt = w_rot_req & (~w_rot_req + NUM_CH'(1));
      w_dbl_gnt = {{NUM_CH{1'b0}}, w_rot_gnt} << i_ptr;
      o_grant   = w_dbl_gnt[NUM_CH-1:0] | w_dbl_gnt[2*NUM_CH-1:NUM_CH];
      o_valid   = |i_req;
   end

endmodule

// File: rtl/energy_regulator_mc.sv
// Multi-channel energy regulator: saturating signed net counter per channel,
// drained as rate-limited round-robin energy_inc / energy_dec pulses.
module energy_regulator_mc
   import energy_regulator_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int DIV_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_inc,
   input  logic [NUM_CH-1:0] ch_dec,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic              ovf_clr,
   output logic              energy_inc,
   output logic              energy_dec,
   output logic              pending_any,
   output logic [NUM_CH-1:0] overflow
);

   localparam int EXT_W = CNT_W + 2;
   localparam int PTR_W = $clog2(NUM_CH);
   localparam logic signed [EXT_W-1:0] W_MAX = EXT_W'(cnt_max(CNT_W));
   localparam logic signed [EXT_W-1:0] W_MIN = EXT_W'(cnt_min(CNT_W));

   state_t                   r_state;
   logic signed [CNT_W-1:0]  r_net [NUM_CH];
   logic [DIV_W-1:0]         r_space;
   logic [PTR_W-1:0]         r_ptr;
   logic                     r_inc;
   logic                     r_dec;
   logic                     r_pend;
   logic [NUM_CH-1:0]        r_ovf;

   logic [NUM_CH-1:0]        w_req;
   logic [NUM_CH-1:0]        w_grant;
   logic                     w_valid;
   logic                     w_opp;
   logic                     w_fire;
   logic [PTR_W-1:0]         w_sel;
   logic [PTR_W-1:0]         w_ptr_nxt;
   logic                     w_sel_neg;
   drain_t                   w_drn [NUM_CH];
   logic signed [EXT_W-1:0]  w_sum [NUM_CH];
   logic signed [CNT_W-1:0]  w_net_next [NUM_CH];
   logic [NUM_CH-1:0]        w_sat;
   logic [NUM_CH-1:0]        w_nz_next;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W)
   ) u_arb (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_valid (w_valid)
   );

   // Request vector, drain opportunity and selected channel attributes.
   always_comb begin
      w_opp     = (r_state == ST_RUN) && (r_space == {DIV_W{1'b0}});
      w_fire    = w_opp && w_valid;
      w_sel     = {PTR_W{1'b0}};
      w_sel_neg = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_req[i] = (r_net[i] != {CNT_W{1'b0}});
         if (w_grant[i]) begin
            w_sel     = PTR_W'(i);
            w_sel_neg = r_net[i][CNT_W-1];
         end else begin
            w_sel     = w_sel;
            w_sel_neg = w_sel_neg;
         end
      end
      w_ptr_nxt = (w_sel == PTR_W'(NUM_CH - 1)) ? {PTR_W{1'b0}} : w_sel + PTR_W'(1);
   end

   // Next net value per channel: input delta minus drain, clamped to the signed range.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_fire && w_grant[i]) begin
            w_drn[i] = r_net[i][CNT_W-1] ? DRN_NEG : DRN_POS;
         end else begin
            w_drn[i] = DRN_NONE;
         end
         w_sum[i] = EXT_W'(r_net[i]) + EXT_W'(in_delta(ch_inc[i], ch_dec[i]))
                    - EXT_W'(drain_val(w_drn[i]));
         if (w_sum[i] > W_MAX) begin
            w_net_next[i] = CNT_W'(W_MAX);
            w_sat[i]      = 1'b1;
         end else if (w_sum[i] < W_MIN) begin
            w_net_next[i] = CNT_W'(W_MIN);
            w_sat[i]      = 1'b1;
         end else begin
            w_net_next[i] = CNT_W'(w_sum[i]);
            w_sat[i]      = 1'b0;
         end
         w_nz_next[i] = (w_net_next[i] != {CNT_W{1'b0}});
      end
   end

   // Counters, sticky flags, pacing FSM and registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_net[i] <= {CNT_W{1'b0}};
         end
         r_state <= ST_IDLE;
         r_space <= {DIV_W{1'b0}};
         r_ptr   <= {PTR_W{1'b0}};
         r_inc   <= 1'b0;
         r_dec   <= 1'b0;
         r_pend  <= 1'b0;
         r_ovf   <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_net[i] <= w_net_next[i];
         end
         // Set beats clear when both happen in the same cycle.
         r_ovf  <= (r_ovf & ~{NUM_CH{ovf_clr}}) | w_sat;
         r_pend <= |w_nz_next;
         r_inc  <= 1'b0;
         r_dec  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_space <= {DIV_W{1'b0}};
               r_state <= r_pend ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
               if (w_opp) begin
                  if (w_valid) begin
                     r_inc   <= ~w_sel_neg;
                     r_dec   <= w_sel_neg;
                     r_space <= rate_div;
                     r_ptr   <= w_ptr_nxt;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_space <= r_space - DIV_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_space <= {DIV_W{1'b0}};
            end
         endcase
      end
   end

   assign energy_inc  = r_inc;
   assign energy_dec  = r_dec;
   assign pending_any = r_pend;
   assign overflow    = r_ovf;

endmodule

// File: doc/energy_regulator_mc.md
Name: energy_regulator_mc

Overview:
Multi-channel, parametrised successor to the single-source energy regulator. It collects inc/dec request pulses from NUM_CH sources, such as the sleep controller, stress, light and nutrition blocks. Each channel's requests are held in a saturating signed net counter. The block drains these counters as a rate-limited, round-robin-arbitrated stream of single-cycle energy_inc / energy_dec pulses to the energy state counter.

Parameters:
NUM_CH, 4, number of request channels (2..8)
CNT_W, 4, width of each signed per-channel net counter (range -2^(CNT_W-1) .. 2^(CNT_W-1)-1)
DIV_W, 4, width of rate_div and of the internal spacing counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ch_inc  input  NUM_CH  per-channel increment request pulse, bit i = channel i
ch_dec  input  NUM_CH  per-channel decrement request pulse
rate_div  input  DIV_W  minimum idle cycles between output pulses (0 = back-to-back)
ovf_clr  input  1  clears all sticky overflow flags
energy_inc  output  1  one-cycle energy increment pulse
energy_dec  output  1  one-cycle energy decrement pulse
pending_any  output  1  high while any net counter is nonzero
overflow  output  NUM_CH  sticky per-channel saturation flags

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset state: all net counters 0; spacing counter 0; rr pointer 0; FSM in IDLE; energy_inc, energy_dec, pending_any and overflow all 0.
- Per-channel input delta:
  - ch_inc only: +1.
  - ch_dec only: -1.
  - Both or neither: 0.
- Per-channel counter update: net_next = sat(net + in_delta - drain_delta).
  - drain_delta is +1 if the channel is drained toward zero from a positive value, -1 if drained from a negative value, 0 otherwise.
  - sat() clamps to the CNT_W signed range.
  - A clamp sets overflow[i]. Otherwise overflow[i] holds its value.
  - ovf_clr clears all flags. If a new saturation and ovf_clr occur in the same cycle, set wins.
- Opportunity: a drain is possible in a cycle where state==RUN and the spacing counter==0.
- FSM states:
  - IDLE: no net counter is nonzero; spacing counter held at 0. Go to RUN when any net_next != 0.
  - RUN: on each opportunity, the arbiter picks the first channel with net != 0, searching from the rr pointer upward with wrap-around.
    - If net > 0: register energy_inc=1 and drain by +1.
    - If net < 0: register energy_dec=1 and drain by -1.
    - Load the spacing counter with rate_div. Set rr pointer = (sel+1) mod NUM_CH.
    - If no channel is nonzero: no pulse, pointer unchanged, return to IDLE.
  - When not at an opportunity: decrement the spacing counter, down to 0.
- Latency: an input pulse sampled at edge E0 updates net at E0. If the FSM was IDLE, the energy pulse is registered at E2 and is high for exactly one cycle. Consecutive pulses are spaced rate_div+1 cycles apart.
- Changes to rate_div take effect at the next counter load.
- energy_inc and energy_dec are mutually exclusive and never high in two consecutive cycles unless rate_div==0.
- The drain uses the current-cycle net value. A simultaneous input on the selected channel combines arithmetically, e.g. net=1 with ch_dec and drain gives net_next=-1.
- pending_any is a registered OR of all net_next != 0.
- Reset mid-stream: all counters and pulses clear on the same edge, and no pulse is emitted in the following cycle.

Decomposition:
- Shared package energy_regulator_pkg holds:
  - FSM state encoding (IDLE=0, RUN=1).
  - Localparams CNT_MAX = 2^(CNT_W-1)-1 and CNT_MIN = -2^(CNT_W-1).
  - Drain-delta encoding.
- One sub-module: rr_arbiter. It takes a NUM_CH request vector and a pointer, and returns a one-hot grant plus a valid bit; it is purely combinational.
- The net counters and FSM live in energy_regulator_mc.

Test Plan:
- Reset, then a single ch_inc[0] pulse with rate_div=0: energy_inc is high for exactly one cycle, 2 edges later; pending_any returns to 0.
- ch_inc[1] held high for 3 cycles with rate_div=2: three energy_inc pulses 3 cycles apart, with no energy_dec.
- NUM_CH=4; channel 0 net +2, channel 2 net -1, channel 3 net +1, rate_div=0: pulse order is inc(ch0), dec(ch2), inc(ch3), inc(ch0), then return to IDLE.
- ch_inc[0] held 10 cycles with CNT_W=4 and rate_div=15: net saturates at 7 and overflow[0] goes 1. ovf_clr clears the flag; ovf_clr in the same cycle as another saturating ch_inc keeps the flag at 1.
- ch_inc[2] and ch_dec[2] high together for 5 cycles: net stays 0, no pulses, FSM stays IDLE.
- Net +3 on channel 1 draining with rate_div=1, then rst asserted between pulses: all outputs are 0 from the next edge, and no residual pulse appears after rst is released.
